core_phase_sequencer: RTL and testbench

Multi-cycle phase sequencer for the RockWave core. It drives the one-hot Fetch/Decode/Execute/Memory/WriteBack phase strobes consumed by the stage blocks, and holds in a phase while that phase reports a stall. It also provides run/halt/single-step control at instruction boundaries, retired-instruction and active-cycle counters, and a stall watchdog. It replaces free-running phase generation and sits between the debug/control interface and every stage top.

---
 rtl/core_phase_sequencer.sv | 143 ++++++++++++++
 tb/tb_core_phase_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_phase_sequencer.sv
// Phase sequencer for the RockWave core: one-hot F/D/E/M/W phase strobes with
// per-phase stall hold, run/halt/single-step control, counters and a stall watchdog.
//
// state        | meaning
// S_HALT       | idle at an instruction boundary, no phase strobe
// S_FETCH      | fetch phase strobe high
// S_DECODE     | decode phase strobe high
// S_EXECUTE    | execute phase strobe high
// S_MEMORY     | memory phase strobe high
// S_WRITEBACK  | writeback phase strobe high, retires when not stalled
module core_phase_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 stall_fetch,
  input  logic                 stall_decode,
  input  logic                 stall_execute,
  input  logic                 stall_memory,
  input  logic                 stall_writeback,
  output logic                 phase_fetch,
  output logic                 phase_decode,
  output logic                 phase_execute,
  output logic                 phase_memory,
  output logic                 phase_writeback,
  output logic                 halted,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [CNT_WIDTH-1:0] cycle,
  output logic                 wdog_err
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_t;

  // Stall counter is just wide enough to hold the watchdog threshold.
  localparam int SW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [SW-1:0] WDOG_MAX = SW'(WDOG_CYCLES);
  localparam logic [SW:0]   WDOG_THR = (SW + 1)'(WDOG_CYCLES);

  state_t        state;
  state_t        state_next;
  logic          step_pending;
  logic          step_pending_next;
  logic          cur_stall;
  logic          stall_active;
  logic          wdog_hit;
  logic [SW-1:0] stall_cnt;
  logic [SW:0]   stall_cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_HALT;
      step_pending <= 1'b0;
    end else begin
      state        <= state_next;
      step_pending <= step_pending_next;
    end
  end

  always_comb begin
    state_next        = state;
    step_pending_next = step_pending;
    cur_stall         = 1'b0;
    case (state)
      S_FETCH:     cur_stall = stall_fetch;
      S_DECODE:    cur_stall = stall_decode;
      S_EXECUTE:   cur_stall = stall_execute;
      S_MEMORY:    cur_stall = stall_memory;
      S_WRITEBACK: cur_stall = stall_writeback;
      default:     cur_stall = 1'b0;
    endcase
    case (state)
      S_HALT: begin
        // run takes priority over step, so a combined request is free-running
        if (run || step) begin
          state_next        = S_FETCH;
          step_pending_next = step & ~run;
        end
      end
      S_FETCH:   if (!cur_stall) state_next = S_DECODE;
      S_DECODE:  if (!cur_stall) state_next = S_EXECUTE;
      S_EXECUTE: if (!cur_stall) state_next = S_MEMORY;
      S_MEMORY:  if (!cur_stall) state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        if (!cur_stall) begin
          state_next        = (run && !step_pending) ? S_FETCH : S_HALT;
          step_pending_next = 1'b0;
        end
      end
      default: begin
        state_next        = S_HALT;
        step_pending_next = 1'b0;
      end
    endcase
  end

  assign phase_fetch     = (state == S_FETCH);
  assign phase_decode    = (state == S_DECODE);
  assign phase_execute   = (state == S_EXECUTE);
  assign phase_memory    = (state == S_MEMORY);
  assign phase_writeback = (state == S_WRITEBACK);
  assign halted          = (state == S_HALT);
  assign retire          = (state == S_WRITEBACK) && !stall_writeback;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
      cycle   <= '0;
    end else begin
      if (retire) instret <= instret + CNT_WIDTH'(1);
      if (state != S_HALT) cycle <= cycle + CNT_WIDTH'(1);
    end
  end

  assign stall_active  = (state != S_HALT) && cur_stall;
  assign stall_cnt_inc = {1'b0, stall_cnt} + (SW + 1)'(1);
  assign wdog_hit      = (WDOG_CYCLES != 0) && stall_active && (stall_cnt_inc >= WDOG_THR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wdog_err  <= 1'b0;
    end else begin
      if (!stall_active) begin
        stall_cnt <= '0;
      end else if (stall_cnt != WDOG_MAX) begin
        stall_cnt <= stall_cnt_inc[SW-1:0];
      end
      if (wdog_hit) wdog_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_phase_sequencer.sv
// Self-checking bench for core_phase_sequencer: three instances (default, 4-bit
// counters with a 4-cycle watchdog, watchdog disabled) against a behavioural model.
module tb_core_phase_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic [4:0] stl_in;

  logic        a_pf, a_pd, a_pe, a_pm, a_pw, a_halted, a_retire, a_wdog;
  logic [31:0] a_instret, a_cycle;
  logic        c_pf, c_pd, c_pe, c_pm, c_pw, c_halted, c_retire, c_wdog;
  logic [3:0]  c_instret, c_cycle;
  logic        z_pf, z_pd, z_pe, z_pm, z_pw, z_halted, z_retire, z_wdog;
  logic [31:0] z_instret, z_cycle;

  core_phase_sequencer #(.CNT_WIDTH(32), .WDOG_CYCLES(255)) u_main (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .stall_fetch(stl_in[0]), .stall_decode(stl_in[1]), .stall_execute(stl_in[2]),
    .stall_memory(stl_in[3]), .stall_writeback(stl_in[4]),
    .phase_fetch(a_pf), .phase_decode(a_pd), .phase_execute(a_pe),
    .phase_memory(a_pm), .phase_writeback(a_pw), .halted(a_halted),
    .retire(a_retire), .instret(a_instret), .cycle(a_cycle), .wdog_err(a_wdog)
  );

  core_phase_sequencer #(.CNT_WIDTH(4), .WDOG_CYCLES(4)) u_small (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .stall_fetch(stl_in[0]), .stall_decode(stl_in[1]), .stall_execute(stl_in[2]),
    .stall_memory(stl_in[3]), .stall_writeback(stl_in[4]),
    .phase_fetch(c_pf), .phase_decode(c_pd), .phase_execute(c_pe),
    .phase_memory(c_pm), .phase_writeback(c_pw), .halted(c_halted),
    .retire(c_retire), .instret(c_instret), .cycle(c_cycle), .wdog_err(c_wdog)
  );

  core_phase_sequencer #(.CNT_WIDTH(32), .WDOG_CYCLES(0)) u_nowd (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .stall_fetch(stl_in[0]), .stall_decode(stl_in[1]), .stall_execute(stl_in[2]),
    .stall_memory(stl_in[3]), .stall_writeback(stl_in[4]),
    .phase_fetch(z_pf), .phase_decode(z_pd), .phase_execute(z_pe),
    .phase_memory(z_pm), .phase_writeback(z_pw), .halted(z_halted),
    .retire(z_retire), .instret(z_instret), .cycle(z_cycle), .wdog_err(z_wdog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase number 0 = halted, 1..5 = F,D,E,M,W.
  int      m_ph = 0;
  bit      m_sp = 0;
  longint  m_instret = 0;
  longint  m_cycle = 0;
  int      m_run_stall = 0;
  bit      m_wd255 = 0;
  bit      m_wd4 = 0;

  logic [23:0]  obs_ctl;
  logic [135:0] obs_cnt;
  assign obs_ctl = {a_halted, a_pf, a_pd, a_pe, a_pm, a_pw, a_retire,
                    c_halted, c_pf, c_pd, c_pe, c_pm, c_pw, c_retire,
                    z_halted, z_pf, z_pd, z_pe, z_pm, z_pw, z_retire,
                    a_wdog, c_wdog, z_wdog};
  assign obs_cnt = {a_instret, a_cycle, c_instret, c_cycle, z_instret, z_cycle};

  function automatic logic [23:0] exp_ctl();
    logic [6:0] v;
    v[6] = (m_ph == 0);
    v[5] = (m_ph == 1);
    v[4] = (m_ph == 2);
    v[3] = (m_ph == 3);
    v[2] = (m_ph == 4);
    v[1] = (m_ph == 5);
    v[0] = (m_ph == 5) && !stl_in[4];
    return {v, v, v, m_wd255, m_wd4, 1'b0};
  endfunction

  function automatic logic [135:0] exp_cnt();
    logic [63:0] i;
    logic [63:0] c;
    i = m_instret;
    c = m_cycle;
    return {i[31:0], c[31:0], i[3:0], c[3:0], i[31:0], c[31:0]};
  endfunction

  function automatic void model_edge();
    bit cur;
    if (!rst_n) begin
      m_ph = 0; m_sp = 0; m_instret = 0; m_cycle = 0;
      m_run_stall = 0; m_wd255 = 0; m_wd4 = 0;
      return;
    end
    cur = (m_ph != 0) ? stl_in[m_ph-1] : 1'b0;
    if (m_ph != 0) m_cycle++;
    if (m_ph == 5 && !cur) m_instret++;
    if (m_ph == 0) begin
      m_run_stall = 0;
      if (run || step) begin
        m_ph = 1;
        m_sp = step && !run;
      end
    end else if (cur) begin
      m_run_stall++;
    end else begin
      m_run_stall = 0;
      if (m_ph < 5) m_ph++;
      else begin
        m_ph = (run && !m_sp) ? 1 : 0;
        m_sp = 0;
      end
    end
    if (m_run_stall >= 255) m_wd255 = 1;
    if (m_run_stall >= 4) m_wd4 = 1;
  endfunction

  task automatic apply(input logic r, input logic s, input logic [4:0] st, input logic rn);
    @(negedge clk);
    rst_n  = rn;
    run    = r;
    step   = s;
    stl_in = st;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 5'b0, 1'b0);
    clock_edge();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_ph != 0; i++) begin
      apply(1'b0, 1'b0, 5'b0, 1'b1);
      clock_edge();
    end
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b0, 1'b0, 5'b0, 1'b1);
    total++;
    if (obs_ctl !== exp_ctl()) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", obs_ctl, exp_ctl());
    end
    total++;
    if (obs_cnt !== exp_cnt()) begin
      bad++; $display("FAIL reset_cnt got=%h want=%h", obs_cnt, exp_cnt());
    end
    total++;
    if ({a_halted, a_pf, a_pd, a_pe, a_pm, a_pw, a_retire, a_wdog} !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_out got=%b want=10000000",
                      {a_halted, a_pf, a_pd, a_pe, a_pm, a_pw, a_retire, a_wdog});
    end
    clock_edge();
  endtask

  task automatic test_run_free();
    do_reset();
    apply(1'b1, 1'b0, 5'b0, 1'b1);
    clock_edge();
    for (int k = 1; k <= 20; k++) begin
      apply(1'b1, 1'b0, 5'b0, 1'b1);
      total++;
      if (obs_ctl !== exp_ctl()) begin
        bad++; $display("FAIL run_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      total++;
      if (obs_cnt !== exp_cnt()) begin
        bad++; $display("FAIL run_cnt k=%0d got=%h want=%h", k, obs_cnt, exp_cnt());
      end
      total++;
      if (a_retire !== (k % 5 == 0) || a_pf !== (k % 5 == 1)) begin
        bad++; $display("FAIL run_period k=%0d got retire=%b fetch=%b want retire=%b fetch=%b",
                        k, a_retire, a_pf, (k % 5 == 0), (k % 5 == 1));
      end
      clock_edge();
    end
    apply(1'b0, 1'b0, 5'b0, 1'b1);
    total++;
    if (a_instret !== 32'd4 || a_cycle !== 32'd20) begin
      bad++; $display("FAIL run_totals got instret=%0d cycle=%0d want instret=4 cycle=20",
                      a_instret, a_cycle);
    end
    drain();
  endtask

  task automatic test_stall_execute();
    int ex_stalls;
    int ex_cycles;
    int busy;
    logic [4:0] st;
    ex_stalls = 0; ex_cycles = 0; busy = 0;
    apply(1'b1, 1'b0, 5'b0, 1'b1);
    clock_edge();
    for (int k = 0; k < 16; k++) begin
      st = 5'b0;
      if (m_ph == 3) begin
        if (ex_stalls < 3) begin
          st[2] = 1'b1;
          ex_stalls++;
        end
        st[0] = k[0];
        st[4] = ~k[0];
      end
      apply(1'b0, 1'b0, st, 1'b1);
      total++;
      if (obs_ctl !== exp_ctl()) begin
        bad++; $display("FAIL stall_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      total++;
      if (obs_cnt !== exp_cnt()) begin
        bad++; $display("FAIL stall_cnt k=%0d got=%h want=%h", k, obs_cnt, exp_cnt());
      end
      if (a_pe === 1'b1) ex_cycles++;
      if (a_halted === 1'b0) busy++;
      clock_edge();
    end
    total++;
    if (ex_cycles !== 4 || busy !== 8) begin
      bad++; $display("FAIL stall_len got exec=%0d instr=%0d want exec=4 instr=8", ex_cycles, busy);
    end
  endtask

  task automatic test_step();
    int  rets;
    bit  sent2;
    logic s;
    rets = 0; sent2 = 0;
    apply(1'b0, 1'b1, 5'b0, 1'b1);
    clock_edge();
    for (int k = 0; k < 12; k++) begin
      s = (m_ph == 2) && !sent2;
      if (s) sent2 = 1;
      apply(1'b0, s, 5'b0, 1'b1);
      total++;
      if (obs_ctl !== exp_ctl()) begin
        bad++; $display("FAIL step_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      if (a_retire === 1'b1) rets++;
      clock_edge();
    end
    apply(1'b0, 1'b0, 5'b0, 1'b1);
    total++;
    if (rets !== 1 || a_halted !== 1'b1) begin
      bad++; $display("FAIL step_once got retires=%0d halted=%b want retires=1 halted=1", rets, a_halted);
    end
  endtask

  task automatic test_run_drop();
    logic [31:0] start;
    bit dropped;
    int rets;
    start = a_instret; dropped = 0; rets = 0;
    apply(1'b1, 1'b0, 5'b0, 1'b1);
    clock_edge();
    for (int k = 0; k < 10; k++) begin
      if (m_ph == 4) dropped = 1;
      apply(!dropped, 1'b0, 5'b0, 1'b1);
      total++;
      if (obs_ctl !== exp_ctl()) begin
        bad++; $display("FAIL drop_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      if (a_retire === 1'b1) rets++;
      clock_edge();
    end
    apply(1'b0, 1'b0, 5'b0, 1'b1);
    total++;
    if (rets !== 1 || a_halted !== 1'b1 || a_instret !== start + 32'd1) begin
      bad++; $display("FAIL drop_finish got retires=%0d halted=%b instret=%0d want 1 1 %0d",
                      rets, a_halted, a_instret, start + 32'd1);
    end
    apply(1'b1, 1'b1, 5'b0, 1'b1);
    clock_edge();
    for (int k = 0; k < 12; k++) begin
      apply(1'b1, 1'b0, 5'b0, 1'b1);
      total++;
      if (obs_ctl !== exp_ctl() || a_halted !== 1'b0) begin
        bad++; $display("FAIL runstep_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      clock_edge();
    end
    drain();
  endtask

  task automatic test_watchdog();
    int  dstalls;
    int  done;
    logic [4:0] st;
    dstalls = 0; done = 0;
    do_reset();
    apply(1'b1, 1'b0, 5'b0, 1'b1);
    clock_edge();
    for (int k = 0; k < 20; k++) begin
      st = 5'b0;
      if (m_ph == 2 && dstalls < 10) begin
        st[1] = 1'b1;
        dstalls++;
      end
      apply(1'b0, 1'b0, st, 1'b1);
      total++;
      if (obs_ctl !== exp_ctl()) begin
        bad++; $display("FAIL wdog_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      total++;
      if (c_wdog !== (done >= 4) || z_wdog !== 1'b0 || a_wdog !== 1'b0) begin
        bad++; $display("FAIL wdog_flag k=%0d got w4=%b w0=%b w255=%b want w4=%b w0=0 w255=0",
                        k, c_wdog, z_wdog, a_wdog, (done >= 4));
      end
      clock_edge();
      if (st[1]) done++;
    end
    apply(1'b0, 1'b0, 5'b0, 1'b1);
    total++;
    if (c_wdog !== 1'b1 || a_halted !== 1'b1 || a_instret !== 32'd1) begin
      bad++; $display("FAIL wdog_sticky got w4=%b halted=%b instret=%0d want 1 1 1", c_wdog, a_halted, a_instret);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1'b1, 1'b0, 5'b0, 1'b1);
    clock_edge();
    for (int k = 1; k <= 80; k++) begin
      apply(1'b1, 1'b0, 5'b0, 1'b1);
      total++;
      if (obs_cnt !== exp_cnt()) begin
        bad++; $display("FAIL wrap_cnt k=%0d got=%h want=%h", k, obs_cnt, exp_cnt());
      end
      if (k == 80) begin
        total++;
        if (c_instret !== 4'd15) begin
          bad++; $display("FAIL wrap_pre got=%0d want=15", c_instret);
        end
      end
      clock_edge();
    end
    apply(1'b0, 1'b0, 5'b0, 1'b1);
    total++;
    if (c_instret !== 4'd0 || c_cycle !== 4'd0 || a_instret !== 32'd16) begin
      bad++; $display("FAIL wrap_post got small=%0d/%0d main=%0d want 0/0 16", c_instret, c_cycle, a_instret);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 1'b0, 5'b0, 1'b1);
    clock_edge();
    for (int k = 0; k < 10 && m_ph != 3; k++) begin
      apply(1'b1, 1'b0, 5'b0, 1'b1);
      clock_edge();
    end
    apply(1'b0, 1'b0, 5'b0, 1'b0);
    total++;
    if (a_pe !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got exec=%b want=1", a_pe);
    end
    clock_edge();
    apply(1'b0, 1'b0, 5'b10000, 1'b1);
    total++;
    if ({a_halted, a_retire} !== 2'b10 || a_instret !== 32'd0 || a_cycle !== 32'd0) begin
      bad++; $display("FAIL rstmid_post got halted=%b retire=%b instret=%0d cycle=%0d want 1 0 0 0",
                      a_halted, a_retire, a_instret, a_cycle);
    end
    total++;
    if (obs_ctl !== exp_ctl() || obs_cnt !== exp_cnt()) begin
      bad++; $display("FAIL rstmid_model got=%b want=%b", obs_ctl, exp_ctl());
    end
    clock_edge();
  endtask

  task automatic test_random();
    logic r_lvl;
    logic s;
    logic rn;
    logic [4:0] st;
    int hi;
    r_lvl = 1'b1;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 14) == 0) r_lvl = ~r_lvl;
      s  = ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 199) != 0);
      hi = ((k / 100) % 2 == 1) ? 3 : 0;
      for (int i = 0; i < 5; i++) st[i] = ($urandom_range(0, 4) < 1 + hi);
      apply(r_lvl, s, st, rn);
      total++;
      if (obs_ctl !== exp_ctl()) begin
        bad++; $display("FAIL rand_ctl k=%0d got=%b want=%b", k, obs_ctl, exp_ctl());
      end
      total++;
      if (obs_cnt !== exp_cnt()) begin
        bad++; $display("FAIL rand_cnt k=%0d got=%h want=%h", k, obs_cnt, exp_cnt());
      end
      clock_edge();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    stl_in = 5'b0;
    test_reset();
    test_run_free();
    test_stall_execute();
    test_step();
    test_run_drop();
    test_watchdog();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
